// File: rtl/updown_counter_param.sv
// updown_counter_param: parametrised up/down counter with wrap/saturate, terminal count and boundary pulse.
// Define UPDOWN_COUNTER_STICKY_EN to add sticky ovf/unf flags with clr_flags.
module updown_counter_param #(
    parameter int     WIDTH   = 4,
    parameter longint MAX_VAL = (longint'(1) << WIDTH) - 1,
    parameter longint STEP    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic             ud,
    input  logic             sat,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
`ifdef UPDOWN_COUNTER_STICKY_EN
    ,
    input  logic             clr_flags,
    output logic             ovf,
    output logic             unf
`endif
);
    localparam logic [WIDTH:0] MAX_E  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] STEP_E = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] MOD_E  = (WIDTH+1)'(MAX_VAL + 1);
    logic [WIDTH:0]   c, d, up_sum, dn_sum;
    logic             hi, lo, bnd, wrap_d;
    logic [WIDTH-1:0] count_d;
    // One extra bit keeps count+STEP and count+MOD from overflowing.
    always_comb begin
        c       = {1'b0, count};
        d       = {1'b0, data};
        hi      = c > MAX_E - STEP_E;
        lo      = c < STEP_E;
        up_sum  = hi ? (sat ? MAX_E : c + STEP_E - MOD_E) : c + STEP_E;
        dn_sum  = lo ? (sat ? '0 : c + (MOD_E - STEP_E)) : c - STEP_E;
        bnd     = ud ? hi & ~(sat & c == MAX_E) : lo & ~(sat & c == '0);
        count_d = WIDTH'(load ? (d > MAX_E ? MAX_E : d) : en ? (ud ? up_sum : dn_sum) : c);
        wrap_d  = ~load & en & bnd;
        tc      = en & ~load & (ud ? hi : lo);
    end
`ifdef UPDOWN_COUNTER_STICKY_EN
    // A set on the same edge as clr_flags wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= count_d;
            wrap  <= wrap_d;
            ovf   <= (wrap_d & ud) | (ovf & ~clr_flags);
            unf   <= (wrap_d & ~ud) | (unf & ~clr_flags);
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            count <= count_d;
            wrap  <= wrap_d;
        end
    end
`endif
endmodule

// File: tb/tb_updown_counter_param.sv
// tb_updown_counter_param: directed checks for updown_counter_param (MAX_VAL=9, STEP=1 and STEP=3).
module tb_updown_counter_param;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0, load = 1'b0, ud = 1'b0, sat = 1'b0;
    logic [3:0] data = '0;
    logic [3:0] count1, count3;
    logic       tc1, tc3, wrap1, wrap3;
    int         n_chk = 0, n_pass = 0;
`ifdef UPDOWN_COUNTER_STICKY_EN
    logic       clr_flags = 1'b0;
    logic       ovf1, unf1, ovf3, unf3;
`endif

    always #5 clk = ~clk;

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP(1)) u1 (
        .clk(clk), .reset(reset), .en(en), .load(load), .ud(ud), .sat(sat), .data(data),
        .count(count1), .tc(tc1), .wrap(wrap1)
`ifdef UPDOWN_COUNTER_STICKY_EN
        , .clr_flags(clr_flags), .ovf(ovf1), .unf(unf1)
`endif
    );

    updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP(3)) u3 (
        .clk(clk), .reset(reset), .en(en), .load(load), .ud(ud), .sat(sat), .data(data),
        .count(count3), .tc(tc3), .wrap(wrap3)
`ifdef UPDOWN_COUNTER_STICKY_EN
        , .clr_flags(clr_flags), .ovf(ovf3), .unf(unf3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        check("rst_count", 32'(count1), 0);
        check("rst_wrap", 32'(wrap1), 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        // async reset mid-count
        load = 1; data = 5; step();
        check("load5", 32'(count1), 5);
        load = 0; en = 1; ud = 1; sat = 0; step();
        check("cnt6", 32'(count1), 6);
        reset = 0; #1;
        check("mid_rst_count", 32'(count1), 0);
        check("mid_rst_wrap", 32'(wrap1), 0);
        reset = 1; step();
        check("post_rst", 32'(count1), 1);
        // wrap up, STEP=1
        en = 0; load = 1; data = 8; step();
        check("load8", 32'(count1), 8);
        load = 0; en = 1; ud = 1; sat = 0; #1;
        check("tc_at8", 32'(tc1), 0);
        step();
        check("up_9", 32'(count1), 9);
        check("up_9_wrap", 32'(wrap1), 0);
        check("up_9_tc", 32'(tc1), 1);
        step();
        check("up_0", 32'(count1), 0);
        check("up_0_wrap", 32'(wrap1), 1);
        check("up_0_tc", 32'(tc1), 0);
        step();
        check("up_1", 32'(count1), 1);
        check("up_1_wrap", 32'(wrap1), 0);
        // saturate down, STEP=3
        en = 0; load = 1; data = 4; step();
        check("s3_load4", 32'(count3), 4);
        load = 0; en = 1; ud = 0; sat = 1; step();
        check("sd_1", 32'(count3), 1);
        check("sd_1_wrap", 32'(wrap3), 0);
        check("sd_1_tc", 32'(tc3), 1);
        step();
        check("sd_0", 32'(count3), 0);
        check("sd_0_wrap", 32'(wrap3), 1);
        step();
        check("sd_0b", 32'(count3), 0);
        check("sd_0b_wrap", 32'(wrap3), 0);
        // wrap down, STEP=3
        en = 0; load = 1; data = 1; step();
        check("s3_load1", 32'(count3), 1);
        load = 0; en = 1; ud = 0; sat = 0; step();
        check("wd_8", 32'(count3), 8);
        check("wd_8_wrap", 32'(wrap3), 1);
        step();
        check("wd_5", 32'(count3), 5);
        check("wd_5_wrap", 32'(wrap3), 0);
        // load priority and clamp
        load = 1; en = 1; ud = 1; data = 4'hF; step();
        check("clamp1", 32'(count1), 9);
        check("clamp3", 32'(count3), 9);
        check("clamp_wrap", 32'(wrap1), 0);
        check("clamp_tc", 32'(tc1), 0);
        load = 0; en = 0;
        for (int i = 0; i < 4; i++) step();
        check("hold9", 32'(count1), 9);
        check("hold_tc", 32'(tc1), 0);
        // saturate up already at MAX: no pulse
        en = 1; ud = 1; sat = 1; step();
        check("su_9", 32'(count1), 9);
        check("su_9_wrap", 32'(wrap1), 0);
`ifdef UPDOWN_COUNTER_STICKY_EN
        en = 0; clr_flags = 1; step();
        check("flags_clr_ovf", 32'(ovf1), 0);
        check("flags_clr_unf", 32'(unf1), 0);
        clr_flags = 0; en = 1; ud = 1; sat = 0; step();
        check("ovf_set_cnt", 32'(count1), 0);
        check("ovf_set", 32'(ovf1), 1);
        en = 0; step();
        check("ovf_sticky", 32'(ovf1), 1);
        en = 1; ud = 0; clr_flags = 1; step();
        check("unf_cnt", 32'(count1), 9);
        check("ovf_cleared", 32'(ovf1), 0);
        check("unf_set", 32'(unf1), 1);
        clr_flags = 0; en = 0;
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
